// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ISA opcodes, datapath constants, flag bundle and
// the opcode-class helpers used by the flag register and hazard logic.
package cpu_pkg;

  localparam int WIDTH = 16;
  localparam int OPW   = 4;
  localparam int RW    = 4;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_t;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
  } flags_t;

  function automatic logic sets_all_flags(opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic sets_z_only(opcode_t op);
    return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/ex_mem_flag_stage_if.sv
// EX -> MEM pipeline bus: the EX-side instruction fields and the registered
// MEM-side copies. The stage is the slave; whoever feeds EX is the master.
interface ex_mem_flag_stage_if #(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int OPW   = cpu_pkg::OPW,
  parameter int RW    = cpu_pkg::RW
);
  logic             ex_valid;
  logic [OPW-1:0]   ex_opcode;
  logic [WIDTH-1:0] ex_result;
  logic             ex_ovf;
  logic [RW-1:0]    ex_rd;
  logic             ex_wr_en;
  logic             ex_mem_rd;
  logic             ex_mem_wr;
  logic [WIDTH-1:0] ex_store_data;

  logic             mem_valid;
  logic [OPW-1:0]   mem_opcode;
  logic [WIDTH-1:0] mem_result;
  logic [RW-1:0]    mem_rd;
  logic             mem_wr_en;
  logic             mem_mem_rd;
  logic             mem_mem_wr;
  logic [WIDTH-1:0] mem_store_data;

  modport master (
    output ex_valid, ex_opcode, ex_result, ex_ovf, ex_rd,
           ex_wr_en, ex_mem_rd, ex_mem_wr, ex_store_data,
    input  mem_valid, mem_opcode, mem_result, mem_rd,
           mem_wr_en, mem_mem_rd, mem_mem_wr, mem_store_data
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_result, ex_ovf, ex_rd,
           ex_wr_en, ex_mem_rd, ex_mem_wr, ex_store_data,
    output mem_valid, mem_opcode, mem_result, mem_rd,
           mem_wr_en, mem_mem_rd, mem_mem_wr, mem_store_data
  );
endinterface

// File: rtl/ex_mem_flag_stage_flag_reg.sv
// Architectural N/Z/V flag register. Each flag has its own write mask taken
// from the opcode class, so Z-only ops leave N and V untouched.
module flag_reg #(
  parameter int WIDTH = cpu_pkg::WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  cpu_pkg::opcode_t  op,
  input  logic [WIDTH-1:0]  result,
  input  logic              ovf,
  output cpu_pkg::flags_t   flags
);

  logic we_nv;
  logic we_z;

  assign we_nv = cpu_pkg::sets_all_flags(op);
  assign we_z  = we_nv | cpu_pkg::sets_z_only(op);

  // NOTE: state is written with <= so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
    end else if (en) begin
      if (we_nv) begin
        flags.n <= result[WIDTH-1];
        flags.v <= ovf;
      end
      if (we_z) begin
        flags.z <= (result == '0);
      end
    end
  end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with flag ownership, stall/flush handling and
// sticky halt detection. Flush beats stall; halt blocks all later accepts.
module ex_mem_flag_stage #(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int OPW   = cpu_pkg::OPW,
  parameter int RW    = cpu_pkg::RW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  ex_mem_flag_stage_if.slave  bus,
  output logic                flag_n,
  output logic                flag_z,
  output logic                flag_v,
  output logic                halted
);

  cpu_pkg::opcode_t op;
  cpu_pkg::flags_t  flags;
  logic             acc;
  logic             is_hlt;

  assign op     = cpu_pkg::opcode_t'(bus.ex_opcode);
  assign is_hlt = (op == cpu_pkg::OP_HLT);
  assign acc    = bus.ex_valid & ~stall & ~flush & ~halted;

  flag_reg #(.WIDTH(WIDTH)) u_flag_reg (
    .clk    (clk),
    .rst    (rst),
    .en     (acc),
    .op     (op),
    .result (bus.ex_result),
    .ovf    (bus.ex_ovf),
    .flags  (flags)
  );

  assign flag_n = flags.n;
  assign flag_z = flags.z;
  assign flag_v = flags.v;

  // NOTE: reset is asynchronous, so it sits in the sensitivity list and
  // clears every register immediately, independent of the clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_valid      <= 1'b0;
      bus.mem_opcode     <= '0;
      bus.mem_result     <= '0;
      bus.mem_rd         <= '0;
      bus.mem_wr_en      <= 1'b0;
      bus.mem_mem_rd     <= 1'b0;
      bus.mem_mem_wr     <= 1'b0;
      bus.mem_store_data <= '0;
      halted             <= 1'b0;
    end else if (flush) begin
      bus.mem_valid      <= 1'b0;
      bus.mem_opcode     <= '0;
      bus.mem_result     <= '0;
      bus.mem_rd         <= '0;
      bus.mem_wr_en      <= 1'b0;
      bus.mem_mem_rd     <= 1'b0;
      bus.mem_mem_wr     <= 1'b0;
      bus.mem_store_data <= '0;
    end else if (!stall) begin
      // Data fields pass straight through; only the controls carry acc.
      bus.mem_valid      <= acc;
      bus.mem_opcode     <= bus.ex_opcode;
      bus.mem_result     <= bus.ex_result;
      bus.mem_rd         <= bus.ex_rd;
      bus.mem_wr_en      <= acc & bus.ex_wr_en & ~is_hlt;
      bus.mem_mem_rd     <= acc & bus.ex_mem_rd;
      bus.mem_mem_wr     <= acc & bus.ex_mem_wr;
      bus.mem_store_data <= bus.ex_store_data;
      if (acc && is_hlt) begin
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Self-checking bench for ex_mem_flag_stage: directed scenarios plus a random
// phase, all compared against an ISA-level reference model kept here.
module tb_ex_mem_flag_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic flush = 1'b0;
  logic flag_n, flag_z, flag_v, halted;

  int checks = 0;
  int errors = 0;

  ex_mem_flag_stage_if bus ();

  ex_mem_flag_stage dut (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall),
    .flush  (flush),
    .bus    (bus),
    .flag_n (flag_n),
    .flag_z (flag_z),
    .flag_v (flag_v),
    .halted (halted)
  );

  always #5 clk = ~clk;

  // Reference model state: what the MEM side and flags should look like.
  logic        m_valid, m_wr_en, m_mrd, m_mwr;
  logic [3:0]  m_op, m_rd;
  logic [15:0] m_res, m_sd;
  logic        m_n, m_z, m_v, m_halt;

  task automatic model_reset();
    m_valid = 0; m_wr_en = 0; m_mrd = 0; m_mwr = 0;
    m_op = 0; m_rd = 0; m_res = 0; m_sd = 0;
    m_n = 0; m_z = 0; m_v = 0; m_halt = 0;
  endtask

  // One clock edge of the architectural behaviour.
  task automatic model_edge();
    bit accepted;
    if (flush) begin
      m_valid = 0; m_wr_en = 0; m_mrd = 0; m_mwr = 0;
      m_op = 0; m_rd = 0; m_res = 0; m_sd = 0;
    end else if (!stall) begin
      accepted = bus.ex_valid && !m_halt;
      m_valid  = accepted;
      m_op     = bus.ex_opcode;
      m_res    = bus.ex_result;
      m_rd     = bus.ex_rd;
      m_sd     = bus.ex_store_data;
      m_wr_en  = accepted && bus.ex_wr_en && (bus.ex_opcode != 4'hF);
      m_mrd    = accepted && bus.ex_mem_rd;
      m_mwr    = accepted && bus.ex_mem_wr;
      if (accepted) begin
        case (bus.ex_opcode)
          4'h0, 4'h1: begin
            m_n = bus.ex_result[15];
            m_z = (bus.ex_result == 16'h0000);
            m_v = bus.ex_ovf;
          end
          4'h2, 4'h4, 4'h5, 4'h6: m_z = (bus.ex_result == 16'h0000);
          4'hF: m_halt = 1;
          default: ;
        endcase
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".mem_valid"},      32'(bus.mem_valid),      32'(m_valid));
    chk({tag, ".mem_opcode"},     32'(bus.mem_opcode),     32'(m_op));
    chk({tag, ".mem_result"},     32'(bus.mem_result),     32'(m_res));
    chk({tag, ".mem_rd"},         32'(bus.mem_rd),         32'(m_rd));
    chk({tag, ".mem_wr_en"},      32'(bus.mem_wr_en),      32'(m_wr_en));
    chk({tag, ".mem_mem_rd"},     32'(bus.mem_mem_rd),     32'(m_mrd));
    chk({tag, ".mem_mem_wr"},     32'(bus.mem_mem_wr),     32'(m_mwr));
    chk({tag, ".mem_store_data"}, 32'(bus.mem_store_data), 32'(m_sd));
    chk({tag, ".flags"}, 32'({flag_n, flag_z, flag_v}), 32'({m_n, m_z, m_v}));
    chk({tag, ".halted"},         32'(halted),             32'(m_halt));
  endtask

  task automatic drive(bit v, logic [3:0] op, logic [15:0] res, bit ovf,
                       logic [3:0] rd, bit we, bit mr, bit mw,
                       logic [15:0] sd, bit st, bit fl);
    @(negedge clk);
    bus.ex_valid = v;  bus.ex_opcode = op; bus.ex_result = res;
    bus.ex_ovf = ovf;  bus.ex_rd = rd;     bus.ex_wr_en = we;
    bus.ex_mem_rd = mr; bus.ex_mem_wr = mw; bus.ex_store_data = sd;
    stall = st; flush = fl;
  endtask

  task automatic step(string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  function automatic logic [15:0] rand_data();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive_random(bit allow_hlt);
    logic [3:0] op;
    op = allow_hlt ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 14));
    drive($urandom_range(0, 3) != 0, op, rand_data(), 1'($urandom),
          4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          16'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
  endtask

  initial begin
    bus.ex_valid = 0; bus.ex_opcode = 0; bus.ex_result = 0; bus.ex_ovf = 0;
    bus.ex_rd = 0; bus.ex_wr_en = 0; bus.ex_mem_rd = 0; bus.ex_mem_wr = 0;
    bus.ex_store_data = 0;
    model_reset();

    // Reset state while held.
    @(posedge clk); #1;
    check_all("reset_hold");
    @(negedge clk); rst = 0;

    // 1: reset pulse between edges mid-operation.
    drive(1, OP_ADD, 16'h1234, 0, 4'h3, 1, 0, 0, 16'hAAAA, 0, 0);
    step("t1_add");
    drive(1, OP_ADD, 16'h8001, 1, 4'h4, 1, 0, 0, 16'h5555, 0, 0);
    #2 rst = 1;
    #1 model_reset();
    check_all("t1_async_rst");
    #1 rst = 0;
    step("t1_after_rst");

    // 2: ADD zero, then saturated SUB with overflow.
    drive(1, OP_ADD, 16'h0000, 0, 4'h1, 1, 0, 0, 16'h0000, 0, 0);
    step("t2_add_zero");
    drive(1, OP_SUB, 16'h8000, 1, 4'h2, 1, 0, 0, 16'h0000, 0, 0);
    step("t2_sub_ovf");

    // 3: XOR touches only Z; LW touches no flags.
    drive(1, OP_XOR, 16'h0000, 0, 4'h5, 1, 0, 0, 16'h0000, 0, 0);
    step("t3_xor_zero");
    drive(1, OP_LW, 16'h0000, 1, 4'h6, 1, 1, 0, 16'h0000, 0, 0);
    step("t3_lw");

    // 4: three stalled cycles with changing inputs, then stall+flush.
    for (int i = 0; i < 3; i++) begin
      drive(1, OP_ADD, 16'h7FFF - 16'(i), 1, 4'(i), 1, 1, 1, 16'(i), 1, 0);
      step("t4_stall");
    end
    drive(1, OP_SUB, 16'h0000, 0, 4'h7, 1, 0, 1, 16'h1111, 1, 1);
    step("t4_stall_flush");

    // 6: invalid instruction with write intents is a bubble.
    drive(0, OP_SUB, 16'h0000, 1, 4'h8, 1, 0, 1, 16'h2222, 0, 0);
    step("t6_invalid");

    // Randomised phase (no halts).
    for (int i = 0; i < 300; i++) begin
      drive_random(0);
      step("rand");
    end

    // 5: halt, frozen afterwards, cleared only by reset.
    drive(1, OP_HLT, 16'h0000, 0, 4'h9, 1, 0, 0, 16'h0000, 0, 0);
    step("t5_hlt");
    drive(1, OP_ADD, 16'h0005, 1, 4'hA, 1, 0, 0, 16'h0000, 0, 0);
    step("t5_after_hlt");
    for (int i = 0; i < 20; i++) begin
      drive_random(1);
      step("t5_halted_rand");
    end
    @(negedge clk); rst = 1;
    #1 model_reset();
    check_all("t5_rst");
    @(negedge clk); rst = 0;
    drive(1, OP_ADD, 16'h8000, 1, 4'hB, 1, 0, 0, 16'h0000, 0, 0);
    step("t5_resume");

    // Randomised phase with halts and periodic resets.
    for (int i = 0; i < 200; i++) begin
      drive_random(1);
      step("rand_hlt");
      if (i % 50 == 49) begin
        @(negedge clk); rst = 1;
        #1 model_reset();
        check_all("rand_rst");
        @(negedge clk); rst = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
